// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - frame sequencer that serializes words into a sequence detector and counts hits
module seq_scan_ctrl #(
    parameter int WORD_W  = 8,
    parameter int CNT_W   = 8,
    parameter int DET_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              det_data,
    output logic              det_rst_n,
    input  logic              det_signal,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              match_sat,
    output logic              busy
);

    localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BW-1:0] BMAX = BW'(WORD_W - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, DRAIN, DONE, CLEAR} state_t;

    state_t             state;
    logic [WORD_W-1:0]  shreg;
    logic [BW-1:0]      bitcnt;
    logic               last;
    logic [DET_LAT-1:0] vpipe;
    logic [2:0]         drain_cnt;
    logic               in_hs;
    logic               hit;

    assign in_hs    = in_valid & in_ready;
    assign hit      = vpipe[DET_LAT-1] & det_signal;
    assign det_data = (state == SHIFT) & shreg[WORD_W-1];
    assign busy     = (state != IDLE);

    // in_ready is registered, so each branch sets the value for the state it enters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            bitcnt    <= '0;
            last      <= 1'b0;
            vpipe     <= '0;
            drain_cnt <= '0;
            match_cnt <= '0;
            match_sat <= 1'b0;
            det_rst_n <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            det_rst_n <= 1'b1;
            vpipe     <= (vpipe << 1) | DET_LAT'(state == SHIFT);

            if (hit) begin
                if (&match_cnt) begin
                    match_sat <= 1'b1;
                end else begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_hs) begin
                        shreg    <= in_data;
                        last     <= in_last;
                        bitcnt   <= BMAX;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg    <= shreg << 1;
                    bitcnt   <= bitcnt - BW'(1);
                    in_ready <= 1'b0;
                    if (bitcnt == BW'(1)) begin
                        in_ready <= !last;
                    end
                    if (bitcnt == '0) begin
                        if (last) begin
                            drain_cnt <= 3'(DET_LAT - 1);
                            state     <= DRAIN;
                        end else if (in_hs) begin
                            shreg  <= in_data;
                            last   <= in_last;
                            bitcnt <= BMAX;
                        end else begin
                            // detector state is kept across the gap
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        det_rst_n <= 1'b0;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    match_cnt <= '0;
                    match_sat <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - scoreboard bench for seq_scan_ctrl with a behavioural sequence detector
module tb_seq_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;
    logic       det_signal;

    logic       in_ready0, det_data0, det_rst_n0, out_valid0, match_sat0, busy0;
    logic [7:0] match_cnt0;
    logic       in_ready1, det_data1, det_rst_n1, out_valid1, match_sat1, busy1;
    logic [1:0] match_cnt1;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.WORD_W(8), .CNT_W(8), .DET_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready0), .det_data(det_data0), .det_rst_n(det_rst_n0), .det_signal(det_signal),
        .out_valid(out_valid0), .out_ready(out_ready), .match_cnt(match_cnt0),
        .match_sat(match_sat0), .busy(busy0)
    );

    seq_scan_ctrl #(.WORD_W(8), .CNT_W(2), .DET_LAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready1), .det_data(det_data1), .det_rst_n(det_rst_n1), .det_signal(det_signal),
        .out_valid(out_valid1), .out_ready(out_ready), .match_cnt(match_cnt1),
        .match_sat(match_sat1), .busy(busy1)
    );

    // non-overlapping 111000 / 101110 detector, one clock of latency
    logic [5:0] hist;
    logic [5:0] hist_n;
    logic       det_match;
    assign hist_n    = {hist[4:0], det_data0};
    assign det_match = (hist_n == 6'b111000) || (hist_n == 6'b101110);

    always @(posedge clk) begin
        if (det_rst_n0 === 1'b0) begin
            hist       <= '0;
            det_signal <= 1'b0;
        end else begin
            det_signal <= det_match;
            hist       <= det_match ? 6'b0 : hist_n;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    c0;
        int    s0;
        int    c1;
        int    s1;
        string name;
    } exp_t;

    exp_t sbq[$];
    logic dlog [0:4095];
    int   errors = 0;
    int   checks = 0;
    int   rise_cyc = 0;
    int   hs_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        bit   ov_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc < 4096) dlog[cyc] = det_data0;
            if (rst_n === 1'b1) begin
                if (out_valid0 === 1'b1 && !ov_prev) rise_cyc = cyc;
                if (out_valid0 === 1'b1 && out_ready === 1'b1) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got cnt %0d with empty scoreboard", match_cnt0);
                    end else begin
                        e = sbq.pop_front();
                        check({e.name, " cnt"}, 32'(match_cnt0), e.c0);
                        check({e.name, " sat"}, 32'(match_sat0), e.s0);
                        check({e.name, " cnt_w2"}, 32'(match_cnt1), e.c1);
                        check({e.name, " sat_w2"}, 32'(match_sat1), e.s1);
                        check({e.name, " valid_w2"}, 32'(out_valid1), 1);
                    end
                end
            end
            ov_prev = (out_valid0 === 1'b1);
        end
    endtask

    task automatic send(input logic [7:0] w, input logic l, input bit from_idle, input int extra);
        int n;
        if (from_idle) begin
            n = 0;
            while (busy0 !== 1'b0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            repeat (extra) @(negedge clk);
        end
        in_data  = w;
        in_last  = l;
        in_valid = 1'b1;
        n = 0;
        while (in_ready0 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready never rose for word %0h", w);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        hs_cyc   = cyc;
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        while (!(out_valid0 === 1'b1 && out_ready === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: out_valid %0b required 1", name, out_valid0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          first;
        int          second;
        int          stable;
        logic [15:0] stream;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", 32'(in_ready0), 0);
        check("rst det_rst_n", 32'(det_rst_n0), 0);
        check("rst out_valid", 32'(out_valid0), 0);
        check("rst busy", 32'(busy0), 0);
        check("rst match_cnt", 32'(match_cnt0), 0);
        check("rst det_data", 32'(det_data0), 0);
        check("rst w2 outputs", {28'd0, in_ready1, det_data1, det_rst_n1, busy1}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-rst det_rst_n", 32'(det_rst_n0), 1);
        check("post-rst in_ready", 32'(in_ready0), 1);

        sbq.push_back('{1, 0, 1, 0, "t1"});
        send(8'hE0, 1'b1, 1'b1, 0);
        first = hs_cyc;
        wait_frame("t1");
        check("t1 latency", rise_cyc - first, 9);

        sbq.push_back('{2, 0, 2, 0, "t2"});
        send(8'hE0, 1'b0, 1'b1, 0);
        first = hs_cyc;
        send(8'hB8, 1'b1, 1'b0, 0);
        check("t2 second handshake cycle", hs_cyc - first, 8);
        wait_frame("t2");
        check("t2 latency", rise_cyc - first, 17);
        for (int i = 0; i < 16; i++) stream[15-i] = dlog[first+i];
        check("t2 bitstream", 32'(stream), 32'h0000E0B8);

        sbq.push_back('{2, 0, 2, 0, "t3"});
        send(8'h2E, 1'b0, 1'b1, 0);
        first = hs_cyc;
        send(8'h38, 1'b1, 1'b1, 2);
        check("t3 gap length", hs_cyc - first, 11);
        wait_frame("t3");

        sbq.push_back('{1, 0, 1, 0, "t3 split"});
        send(8'h01, 1'b0, 1'b1, 0);
        first = hs_cyc;
        send(8'hE0, 1'b1, 1'b1, 0);
        check("t3 split gap", hs_cyc - first, 9);
        wait_frame("t3 split");

        out_ready = 1'b0;
        sbq.push_back('{1, 0, 1, 0, "t4"});
        send(8'hE0, 1'b1, 1'b1, 0);
        for (int n = 0; n < 100 && out_valid0 !== 1'b1; n++) @(negedge clk);
        stable = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid0 === 1'b1 && match_cnt0 === 8'd1 && in_ready0 === 1'b0) stable++;
        end
        check("t4 hold stable cycles", stable, 5);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_frame("t4");
        check("t4 clear det_rst_n", 32'(det_rst_n0), 0);
        check("t4 clear in_ready", 32'(in_ready0), 0);
        @(posedge clk);
        #1;
        check("t4 after det_rst_n", 32'(det_rst_n0), 1);
        check("t4 after in_ready", 32'(in_ready0), 1);
        check("t4 after match_cnt", 32'(match_cnt0), 0);

        sbq.push_back('{3, 0, 3, 0, "t5 three"});
        send(8'hE0, 1'b0, 1'b1, 0);
        send(8'hE0, 1'b0, 1'b0, 0);
        send(8'hE0, 1'b1, 1'b0, 0);
        wait_frame("t5 three");

        sbq.push_back('{5, 0, 3, 1, "t5 five"});
        for (int i = 0; i < 5; i++) send(8'hE0, (i == 4), (i == 0), 0);
        wait_frame("t5 five");

        send(8'hE0, 1'b0, 1'b1, 0);
        send(8'hFF, 1'b0, 1'b0, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("t6 pre-reset cnt", 32'(match_cnt0), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t6 busy", 32'(busy0), 0);
        check("t6 det_rst_n", 32'(det_rst_n0), 0);
        check("t6 det_data", 32'(det_data0), 0);
        check("t6 match_cnt", 32'(match_cnt0), 0);
        check("t6 out_valid", 32'(out_valid0), 0);
        check("t6 in_ready", 32'(in_ready0), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6 det_rst_n release", 32'(det_rst_n0), 1);
        sbq.push_back('{1, 0, 1, 0, "t6 next"});
        send(8'hE0, 1'b1, 1'b1, 0);
        wait_frame("t6 next");
        check("scoreboard drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
